// File: rtl/ariane_pkg.sv
`default_nettype none
// ============================================================================
// ariane_pkg : shared types for the issue/dispatch path       rev 1.0
// ============================================================================
package ariane_pkg;

  localparam bit          FP_PRESENT    = 1'b1;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC
  } fu_t;

  typedef enum logic [6:0] {
    ADD, SUB, ANDL, ORL, XORL, SLTS, SLTU, EQ, NE, LTS, JALR,
    LD, SD, MUL, DIV, CSR_READ, CSR_WRITE, FADD, FMUL
  } fu_op;

  typedef struct packed {
    fu_t                      fu;
    fu_op                     operator;
    logic [63:0]              operand_a;
    logic [63:0]              operand_b;
    logic [63:0]              imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] predict_address;
    logic        predict_taken;
  } branchpredict_sbe_t;

  localparam int unsigned NR_FU_VALIDS = 6;
  localparam int unsigned ALU_IDX      = 0;
  localparam int unsigned BRANCH_IDX   = 1;
  localparam int unsigned CSR_IDX      = 2;
  localparam int unsigned MULT_IDX     = 3;
  localparam int unsigned LSU_IDX      = 4;
  localparam int unsigned FPU_IDX      = 5;

  // One-hot select of the execute-stage valid line owned by a functional unit.
  function automatic logic [NR_FU_VALIDS-1:0] fu_valid_sel(input fu_t fu);
    logic [NR_FU_VALIDS-1:0] sel;
    sel = '0;
    case (fu)
      ALU:          sel[ALU_IDX]    = 1'b1;
      CTRL_FLOW:    sel[BRANCH_IDX] = 1'b1;
      CSR:          sel[CSR_IDX]    = 1'b1;
      MULT:         sel[MULT_IDX]   = 1'b1;
      LOAD, STORE:  sel[LSU_IDX]    = 1'b1;
      FPU, FPU_VEC: sel[FPU_IDX]    = 1'b1;
      default:      sel             = '0;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fu_dispatch.sv
`default_nettype none
// ============================================================================
// fu_dispatch : accepts one issued instruction per cycle and steers it to a FU
// rev 1.0
// ============================================================================
module fu_dispatch
  import ariane_pkg::*;
#(
  parameter bit FpPresent = ariane_pkg::FP_PRESENT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  input  fu_data_t           issue_data_i,
  input  logic [63:0]        issue_pc_i,
  input  logic               issue_is_compressed_i,
  input  branchpredict_sbe_t issue_bp_i,
  output logic               issue_ack_o,
  input  logic               flu_ready_i,
  input  logic               lsu_ready_i,
  input  logic               fpu_ready_i,
  input  logic               resolve_branch_i,
  output fu_data_t           fu_data_o,
  output logic [63:0]        pc_o,
  output logic               is_compressed_o,
  output branchpredict_sbe_t branch_predict_o,
  output logic               alu_valid_o,
  output logic               branch_valid_o,
  output logic               csr_valid_o,
  output logic               mult_valid_o,
  output logic               lsu_valid_o,
  output logic               fpu_valid_o,
  output logic               stall_o
);

  logic [NR_FU_VALIDS-1:0] valid_d, valid_q;
  logic                    mult_ack_d, mult_ack_q;
  logic                    branch_pending_d, branch_pending_q;
  fu_data_t                fu_data_q;
  logic [63:0]             pc_q;
  logic                    is_compressed_q;
  branchpredict_sbe_t      bp_q;
  logic                    fu_ok;
  logic                    issue_ack;

  // The cycle after a MULT ack the FLU writeback port belongs to the
  // multiplier, so single-cycle FLU ops must wait one cycle.
  always_comb begin
    fu_ok = 1'b0;
    case (issue_data_i.fu)
      ALU, CSR:     fu_ok = flu_ready_i && !mult_ack_q;
      CTRL_FLOW:    fu_ok = flu_ready_i && !mult_ack_q && !branch_pending_q;
      MULT:         fu_ok = flu_ready_i;
      LOAD, STORE:  fu_ok = lsu_ready_i;
      FPU, FPU_VEC: fu_ok = FpPresent && fpu_ready_i;
      NONE:         fu_ok = 1'b1;
      default:      fu_ok = 1'b0;
    endcase

    issue_ack  = rst_ni && issue_valid_i && !flush_i && fu_ok;
    valid_d    = issue_ack ? fu_valid_sel(issue_data_i.fu) : '0;
    mult_ack_d = issue_ack && (issue_data_i.fu == MULT);

    branch_pending_d = branch_pending_q;
    if (flush_i) begin
      branch_pending_d = 1'b0;
    end else if (issue_ack && (issue_data_i.fu == CTRL_FLOW)) begin
      branch_pending_d = 1'b1;
    end else if (resolve_branch_i) begin
      branch_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q          <= '0;
      mult_ack_q       <= 1'b0;
      branch_pending_q <= 1'b0;
      fu_data_q        <= '0;
      pc_q             <= '0;
      is_compressed_q  <= 1'b0;
      bp_q             <= '0;
    end else begin
      valid_q          <= valid_d;
      mult_ack_q       <= mult_ack_d;
      branch_pending_q <= branch_pending_d;
      if (issue_ack) begin
        fu_data_q       <= issue_data_i;
        pc_q            <= issue_pc_i;
        is_compressed_q <= issue_is_compressed_i;
        bp_q            <= issue_bp_i;
      end
    end
  end

  assign issue_ack_o      = issue_ack;
  assign stall_o          = issue_valid_i && !issue_ack;
  assign fu_data_o        = fu_data_q;
  assign pc_o             = pc_q;
  assign is_compressed_o  = is_compressed_q;
  assign branch_predict_o = bp_q;
  assign alu_valid_o      = valid_q[ALU_IDX];
  assign branch_valid_o   = valid_q[BRANCH_IDX];
  assign csr_valid_o      = valid_q[CSR_IDX];
  assign mult_valid_o     = valid_q[MULT_IDX];
  assign lsu_valid_o      = valid_q[LSU_IDX];
  assign fpu_valid_o      = valid_q[FPU_IDX];

endmodule
`default_nettype wire

// File: tb/tb_fu_dispatch.sv
`default_nettype none
// ============================================================================
// tb_fu_dispatch : directed vector table plus multi-cycle sequences   rev 1.0
// ============================================================================
module tb_fu_dispatch;
  import ariane_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_ni, flush_i, issue_valid_i, issue_is_compressed_i;
  fu_data_t           issue_data_i;
  logic [63:0]        issue_pc_i;
  branchpredict_sbe_t issue_bp_i;
  logic               flu_ready_i, lsu_ready_i, fpu_ready_i, resolve_branch_i;

  logic               ack, stall, isc;
  fu_data_t           fu_data;
  logic [63:0]        pc;
  branchpredict_sbe_t bp;
  logic               v_alu, v_br, v_csr, v_mul, v_lsu, v_fpu;

  logic               nf_ack, nf_stall, nf_isc;
  fu_data_t           nf_fu_data;
  logic [63:0]        nf_pc;
  branchpredict_sbe_t nf_bp;
  logic               nf_alu, nf_br, nf_csr, nf_mul, nf_lsu, nf_fpu;

  logic [5:0] vld;
  assign vld = {v_fpu, v_lsu, v_mul, v_csr, v_br, v_alu};

  always #5 clk_i = ~clk_i;

  fu_dispatch dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_data_i(issue_data_i),
    .issue_pc_i(issue_pc_i), .issue_is_compressed_i(issue_is_compressed_i),
    .issue_bp_i(issue_bp_i), .issue_ack_o(ack),
    .flu_ready_i(flu_ready_i), .lsu_ready_i(lsu_ready_i), .fpu_ready_i(fpu_ready_i),
    .resolve_branch_i(resolve_branch_i),
    .fu_data_o(fu_data), .pc_o(pc), .is_compressed_o(isc), .branch_predict_o(bp),
    .alu_valid_o(v_alu), .branch_valid_o(v_br), .csr_valid_o(v_csr),
    .mult_valid_o(v_mul), .lsu_valid_o(v_lsu), .fpu_valid_o(v_fpu),
    .stall_o(stall)
  );

  fu_dispatch #(.FpPresent(1'b0)) dut_nofp (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_data_i(issue_data_i),
    .issue_pc_i(issue_pc_i), .issue_is_compressed_i(issue_is_compressed_i),
    .issue_bp_i(issue_bp_i), .issue_ack_o(nf_ack),
    .flu_ready_i(flu_ready_i), .lsu_ready_i(lsu_ready_i), .fpu_ready_i(fpu_ready_i),
    .resolve_branch_i(resolve_branch_i),
    .fu_data_o(nf_fu_data), .pc_o(nf_pc), .is_compressed_o(nf_isc), .branch_predict_o(nf_bp),
    .alu_valid_o(nf_alu), .branch_valid_o(nf_br), .csr_valid_o(nf_csr),
    .mult_valid_o(nf_mul), .lsu_valid_o(nf_lsu), .fpu_valid_o(nf_fpu),
    .stall_o(nf_stall)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] pc_of(input logic [2:0] tid);
    return 64'h8000_0000 + 64'(tid) * 64'd4;
  endfunction

  task automatic offer(input fu_t f, input logic [2:0] tid);
    issue_valid_i          = 1'b1;
    issue_data_i           = '0;
    issue_data_i.fu        = f;
    issue_data_i.operator  = ADD;
    issue_data_i.operand_a = 64'h100 + 64'(tid);
    issue_data_i.operand_b = 64'h200 + 64'(tid);
    issue_data_i.trans_id  = tid;
    issue_pc_i             = pc_of(tid);
    issue_is_compressed_i  = tid[0];
    issue_bp_i             = '0;
    issue_bp_i.valid       = (f == CTRL_FLOW);
    issue_bp_i.predict_address = pc_of(tid) + 64'd8;
  endtask

  task automatic idle();
    issue_valid_i    = 1'b0;
    flush_i          = 1'b0;
    resolve_branch_i = 1'b0;
  endtask

  typedef struct {
    fu_t        fu;
    logic [2:0] tid;
    logic       flu, lsu, fpu;
    logic       exp_ack;
    logic [5:0] exp_vld;  // {fpu,lsu,mult,csr,branch,alu}
  } vec_t;

  vec_t vt[14];
  logic [2:0] last_tid;

  initial begin
    vt[0]  = '{ALU,       3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b000001};
    vt[1]  = '{ALU,       3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000000};
    vt[2]  = '{CSR,       3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 6'b000100};
    vt[3]  = '{CTRL_FLOW, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 6'b000010};
    vt[4]  = '{MULT,      3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 6'b001000};
    vt[5]  = '{MULT,      3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000000};
    vt[6]  = '{LOAD,      3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 6'b010000};
    vt[7]  = '{STORE,     3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b010000};
    vt[8]  = '{STORE,     3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 6'b000000};
    vt[9]  = '{FPU,       3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 6'b100000};
    vt[10] = '{FPU_VEC,   3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 6'b100000};
    vt[11] = '{FPU,       3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000};
    vt[12] = '{NONE,      3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
    vt[13] = '{CTRL_FLOW, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 6'b000000};

    // Reset state, and no ack while held in reset.
    rst_ni = 1'b0;
    idle();
    flu_ready_i = 1'b1; lsu_ready_i = 1'b1; fpu_ready_i = 1'b1;
    issue_data_i = '0; issue_pc_i = '0; issue_is_compressed_i = 1'b0; issue_bp_i = '0;
    #12;
    chk("reset_valids", 64'(vld), 64'd0);
    chk("reset_trans_id", 64'(fu_data.trans_id), 64'd0);
    chk("reset_pc", pc, 64'd0);
    offer(NONE, 3'd2);
    #1;
    chk("ack_in_reset", 64'(ack), 64'd0);
    idle();
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Vector table: one offer, then an idle cycle with a (possibly stray) resolve.
    last_tid = 3'd0;
    for (int i = 0; i < 14; i++) begin
      offer(vt[i].fu, vt[i].tid);
      flu_ready_i = vt[i].flu; lsu_ready_i = vt[i].lsu; fpu_ready_i = vt[i].fpu;
      #1;
      chk($sformatf("vec%0d_ack", i), 64'(ack), 64'(vt[i].exp_ack));
      chk($sformatf("vec%0d_stall", i), 64'(stall), 64'(!vt[i].exp_ack));
      tick();
      if (vt[i].exp_ack) last_tid = vt[i].tid;
      idle();
      resolve_branch_i = 1'b1;
      chk($sformatf("vec%0d_valids", i), 64'(vld), 64'(vt[i].exp_vld));
      chk($sformatf("vec%0d_trans_id", i), 64'(fu_data.trans_id), 64'(last_tid));
      chk($sformatf("vec%0d_pc", i), pc, pc_of(last_tid));
      tick();
      chk($sformatf("vec%0d_valids_clear", i), 64'(vld), 64'd0);
      idle();
    end
    flu_ready_i = 1'b1; lsu_ready_i = 1'b1; fpu_ready_i = 1'b1;

    // ALU trans_id 3: ack in N, valid only in N+1.
    offer(ALU, 3'd3);
    #1; chk("alu_ack", 64'(ack), 64'd1);
    tick(); idle();
    chk("alu_valid_n1", 64'(vld), 64'b000001);
    chk("alu_trans_id", 64'(fu_data.trans_id), 64'd3);
    chk("alu_operand_a", fu_data.operand_a, 64'h103);
    chk("alu_is_compressed", 64'(isc), 64'd1);
    tick();
    chk("alu_valid_n2", 64'(vld), 64'd0);

    // MULT then ALU: ALU blocked for one cycle.
    offer(MULT, 3'd1);
    #1; chk("mult_ack", 64'(ack), 64'd1);
    tick();
    offer(ALU, 3'd2);
    #1;
    chk("alu_after_mult_ack", 64'(ack), 64'd0);
    chk("alu_after_mult_stall", 64'(stall), 64'd1);
    chk("mult_valid", 64'(vld), 64'b001000);
    tick();
    #1; chk("alu_after_mult_ack_n2", 64'(ack), 64'd1);
    tick(); idle();
    chk("alu_after_mult_valid", 64'(vld), 64'b000001);
    chk("alu_after_mult_tid", 64'(fu_data.trans_id), 64'd2);
    tick();

    // Branch pending: second CTRL_FLOW waits for resolve in N+4, acks in N+5.
    offer(CTRL_FLOW, 3'd4);
    #1; chk("br1_ack", 64'(ack), 64'd1);
    tick();
    chk("br1_valid", 64'(vld), 64'b000010);
    chk("br1_bp_valid", 64'(bp.valid), 64'd1);
    chk("br1_bp_addr", bp.predict_address, pc_of(3'd4) + 64'd8);
    offer(CTRL_FLOW, 3'd5);
    for (int c = 1; c <= 4; c++) begin
      resolve_branch_i = (c == 4);
      #1;
      chk($sformatf("br2_blocked_n%0d", c), 64'(ack), 64'd0);
      tick();
    end
    resolve_branch_i = 1'b0;
    #1; chk("br2_ack_n5", 64'(ack), 64'd1);
    tick(); idle();
    chk("br2_valid", 64'(vld), 64'b000010);
    chk("br2_tid", 64'(fu_data.trans_id), 64'd5);
    resolve_branch_i = 1'b1;
    tick(); idle();

    // LOAD waits three cycles for the LSU, one-cycle valid.
    offer(LOAD, 3'd6);
    lsu_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("load_wait%0d", c), 64'(ack), 64'd0);
      tick();
      chk($sformatf("load_wait_valid%0d", c), 64'(vld), 64'd0);
    end
    lsu_ready_i = 1'b1;
    #1; chk("load_ack", 64'(ack), 64'd1);
    tick(); idle();
    chk("load_valid", 64'(vld), 64'b010000);
    tick();
    chk("load_valid_once", 64'(vld), 64'd0);

    // Flush the cycle after a branch ack: pending cleared, new branch acks at once.
    offer(CTRL_FLOW, 3'd1);
    #1; chk("fl_br_ack", 64'(ack), 64'd1);
    tick();
    offer(ALU, 3'd2);
    flush_i = 1'b1;
    #1; chk("fl_ack_blocked", 64'(ack), 64'd0);
    tick();
    flush_i = 1'b0;
    chk("fl_valids_clear", 64'(vld), 64'd0);
    offer(CTRL_FLOW, 3'd3);
    #1; chk("fl_new_br_ack", 64'(ack), 64'd1);
    tick(); idle();
    chk("fl_new_br_valid", 64'(vld), 64'b000010);
    resolve_branch_i = 1'b1;
    tick(); idle();

    // Flush right after a MULT ack clears the writeback hazard too.
    offer(MULT, 3'd4);
    tick();
    idle(); flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    offer(ALU, 3'd5);
    #1; chk("fl_mult_alu_ack", 64'(ack), 64'd0 + 64'd1);
    tick(); idle();

    // No FP unit: ten cycles stalled; the FP-enabled copy acks back-to-back.
    offer(FPU, 3'd6);
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("nofp_ack%0d", c), 64'(nf_ack), 64'd0);
      chk($sformatf("nofp_stall%0d", c), 64'(nf_stall), 64'd1);
      chk($sformatf("fp_b2b_ack%0d", c), 64'(ack), 64'd1);
      tick();
      chk($sformatf("fp_b2b_valid%0d", c), 64'(v_fpu), 64'd1);
      chk($sformatf("nofp_valid%0d", c), 64'(nf_fpu), 64'd0);
    end
    idle();
    tick();

    // Asynchronous reset mid-operation drops a pending valid immediately.
    offer(ALU, 3'd7);
    tick(); idle();
    chk("mid_alu_valid", 64'(v_alu), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_reset_valid", 64'(vld), 64'd0);
    chk("mid_reset_tid", 64'(fu_data.trans_id), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
